// File: rtl/fetch_decode_stage.sv
// rtl/fetch_decode_stage.sv - RV32 fetch stage with IF/ID pipeline register.
// Zero-latency imem handshake, hazard-unit stall/flush, saturating bubble/redirect counters.
module fetch_decode_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic [4:0]  RdD,
  output logic [15:0] bubble_cnt,
  output logic [15:0] redirect_cnt
);

  typedef enum logic [1:0] {BOOT, FETCH, MISS} state_t;

  state_t      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pc4d_q, pc4d_d;
  logic        valid_q, valid_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic [15:0] redirect_cnt_q, redirect_cnt_d;
  logic [31:0] pcf_plus4;
  logic        fetch_ok;
  logic        write_bubble;

  always_comb begin
    state_d        = state_q;
    pcf_d          = pcf_q;
    instr_d        = instr_q;
    pcd_d          = pcd_q;
    pc4d_d         = pc4d_q;
    valid_d        = valid_q;
    bubble_cnt_d   = bubble_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    pcf_plus4      = pcf_q + 32'd4;
    // A redirect while missing abandons the outstanding fetch, so its data is never usable.
    fetch_ok       = (state_q != BOOT) && imem_ready && !(state_q == MISS && PCSrcE);
    write_bubble   = FlushD || (!StallD && !fetch_ok);

    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   if (!imem_ready && !PCSrcE) state_d = MISS;
      MISS:    if (imem_ready || PCSrcE) state_d = FETCH;
      default: state_d = BOOT;
    endcase

    if (PCSrcE) begin
      pcf_d = PCTargetE;
    end else if (state_q != BOOT && !StallF && imem_ready) begin
      pcf_d = pcf_plus4;
    end

    if (write_bubble) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      if (bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
    end else if (!StallD) begin
      instr_d = imem_rdata;
      pcd_d   = pcf_q;
      pc4d_d  = pcf_plus4;
      valid_d = 1'b1;
    end

    if (PCSrcE && redirect_cnt_q != 16'hFFFF) redirect_cnt_d = redirect_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= BOOT;
      pcf_q          <= RESET_VECTOR;
      instr_q        <= NOP_INSTR;
      pcd_q          <= 32'd0;
      pc4d_q         <= 32'd0;
      valid_q        <= 1'b0;
      bubble_cnt_q   <= 16'd0;
      redirect_cnt_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      pcf_q          <= pcf_d;
      instr_q        <= instr_d;
      pcd_q          <= pcd_d;
      pc4d_q         <= pc4d_d;
      valid_q        <= valid_d;
      bubble_cnt_q   <= bubble_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign imem_req     = (state_q != BOOT);
  assign imem_addr    = pcf_q;
  assign InstrD       = instr_q;
  assign PCD          = pcd_q;
  assign PCPlus4D     = pc4d_q;
  assign ValidD       = valid_q;
  assign Rs1D         = instr_q[19:15];
  assign Rs2D         = instr_q[24:20];
  assign RdD          = instr_q[11:7];
  assign bubble_cnt   = bubble_cnt_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule
